dmux_router: RTL
================

# dmux_router

Parametrised, registered successor to the 8-way demultiplexor: routes a WIDTH-bit word with valid/ready handshake to one of N output channels, or broadcasts it to all. Each channel owns a one-deep output register, so a stalled consumer blocks only its own channel. Used wherever a Hack-side producer (memory-mapped write path, I/O fan-out) must feed several independent sinks with backpressure.

## Interface
Parameters:
- WIDTH, 16, data word width (>=1)
- N, 8, number of output channels (>=2; need not be a power of two)
- SEL_W, $clog2(N), select width (derived; do not override)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  producer offers a word
- in_ready  output  1  router can accept the offered word this cycle
- in_data  input  WIDTH  word offered
- in_sel  input  SEL_W  destination channel index
- in_bcast  input  1  1 = deliver to all N channels, in_sel ignored
- out_valid  output  N  bit k: channel k register holds a word
- out_ready  input  N  bit k: consumer k takes the word this cycle
- out_data  output  N*WIDTH  channel k word at bits [k*WIDTH +: WIDTH]
- drop_count  output  8  saturating count of words discarded for in_sel >= N

## Operation
- Per channel k: state full[k] (=out_valid[k]) and data register. Drain: out_valid[k] && out_ready[k] clears full[k] unless refilled same cycle.
- Channel k can load when free_k = !full[k] || out_ready[k].
- in_ready (combinational, independent of in_valid):
  - in_bcast=1: AND of free_k over all k.
  - in_bcast=0, in_sel < N: free_{in_sel}.
  - in_bcast=0, in_sel >= N: 1 (word discarded).
- Accept = in_valid && in_ready. On accept:
  - unicast, legal sel: load in_data into channel in_sel, full set.
  - broadcast: load in_data into every channel, all full set.
  - illegal sel: no channel written; drop_count increments, saturating at 255.
- Simultaneous drain and load on same channel: load wins, out_valid stays 1, new data visible next cycle (full throughput, 1 word/cycle/channel).
- Producer must hold in_data/in_sel/in_bcast stable while in_valid=1 and in_ready=0. The router never drops a legal accepted word and never duplicates one.
- Channels not addressed hold their data and valid unchanged; out_data of an empty channel holds its last value (don't-care).

## Timing
- Reset (async assert, sync release on next clk edge): out_valid = 0, all out_data = 0, drop_count = 0. in_ready then reflects free channels (1 for any sel).
- Latency: accept in cycle t -> out_valid[k]=1 with data in cycle t+1.
- in_ready has combinational paths from out_ready, in_sel, in_bcast; out_valid/out_data/drop_count are pure registers.
- Reset asserted mid-transfer: all held words are lost, no partial state survives.
- Broadcast with any channel full and its out_ready=0: in_ready=0, no channel written (all-or-nothing).

## Test plan
- Reset then unicast: in_sel=3, in_data=16'hBEEF, in_valid=1 one cycle -> next cycle out_valid=8'b0000_1000, channel 3 data 16'hBEEF, in_ready for sel 3 drops to 0 while out_ready[3]=0.
- Backpressure: channel 5 full, out_ready[5]=0, offer sel=5 for 4 cycles -> in_ready=0 throughout; raise out_ready[5] -> accept same cycle, new word in channel 5 next cycle, out_valid[5] stays 1.
- Streaming: out_ready=all 1, 10 consecutive words 0..9 to sel=0 -> channel 0 shows 0..9 on consecutive cycles, in_ready never 0.
- Broadcast: in_bcast=1, data 16'h1234, all free -> next cycle out_valid=8'hFF, every channel 16'h1234; repeat with channel 2 full and out_ready[2]=0 -> in_ready=0, no channel changes.
- N=6 instance: in_sel=7 accepted 300 times -> in_ready=1, out_valid unchanged, drop_count saturates at 255.
- Async reset mid-stream with channels 1,4 full -> out_valid=0, out_data=0, drop_count=0 immediately, before next clk edge.

Source files
------------

// File: rtl/dmux_router_if.sv
// Handshake bundle between one producer, the router and N consumers.
// The slave side is the router; the master side drives words in and drains channels.
interface dmux_router_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 8,
    parameter int unsigned SEL_W = $clog2(N)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [SEL_W-1:0]     in_sel;
    logic                 in_bcast;
    logic [N-1:0]         out_valid;
    logic [N-1:0]         out_ready;
    logic [N*WIDTH-1:0]   out_data;
    logic [7:0]           drop_count;

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, drop_count
    );

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, drop_count
    );
endinterface

// File: rtl/dmux_router.sv
// Registered 1-to-N word router with per-channel one-deep output registers,
// unicast/broadcast delivery and a saturating counter of words sent to absent channels.
module dmux_router #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned N     = 8,
    parameter int unsigned SEL_W = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    dmux_router_if.slave   bus
);
    localparam int unsigned DW = N * WIDTH;

    logic [N-1:0]  full_q, full_d;
    logic [DW-1:0] data_q, data_d;
    logic [7:0]    drop_q, drop_d;

    logic [N-1:0]  free_c;
    logic [N-1:0]  load_c;
    logic          sel_legal_c;
    logic          sel_free_c;
    logic          ready_c;
    logic          accept_c;

    // Handshake decode: which channels can take a word and whether this one is accepted.
    always_comb begin
        free_c      = ~full_q | bus.out_ready;
        sel_legal_c = 1'b0;
        sel_free_c  = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (bus.in_sel == SEL_W'(k)) begin
                sel_legal_c = 1'b1;
                sel_free_c  = free_c[k];
            end
        end

        if (bus.in_bcast)
            ready_c = &free_c;
        else if (sel_legal_c)
            ready_c = sel_free_c;
        else
            ready_c = 1'b1;

        accept_c = bus.in_valid & ready_c;
    end

    // Next state: a load in the same cycle as a drain keeps the channel full.
    always_comb begin
        load_c = '0;
        data_d = data_q;
        for (int unsigned k = 0; k < N; k++) begin
            load_c[k] = accept_c & (bus.in_bcast | (sel_legal_c & (bus.in_sel == SEL_W'(k))));
            if (load_c[k])
                data_d[k*WIDTH +: WIDTH] = bus.in_data;
        end
        full_d = (full_q & ~bus.out_ready) | load_c;

        drop_d = drop_q;
        if (accept_c && !bus.in_bcast && !sel_legal_c && drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= '0;
            data_q <= '0;
            drop_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            drop_q <= drop_d;
        end
    end

    assign bus.in_ready   = ready_c;
    assign bus.out_valid  = full_q;
    assign bus.out_data   = data_q;
    assign bus.drop_count = drop_q;
endmodule
